// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch sequencer: increment, jump, relative branch, stall and halt,
// with out-of-image fetch detection.
module pc_fetch_ctrl #(
    parameter int unsigned PC_W     = 16,
    parameter int unsigned OFF_W    = 8,
    parameter int unsigned PROG_LEN = 256,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             stall,
    input  logic             jump_en,
    input  logic [PC_W-1:0]  jump_addr,
    input  logic             branch_en,
    input  logic [OFF_W-1:0] branch_off,
    input  logic             halt,
    output logic [PC_W-1:0]  pc,
    output logic             pc_valid,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted,
        StFault
    } state_e;

    // One extra bit so PROG_LEN == 2^PC_W is representable.
    localparam logic [PC_W:0] ProgLen = (PC_W + 1)'(PROG_LEN);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  branch_sext;
    logic [PC_W-1:0]  next_pc;
    logic             next_ok;
    logic             start_ok;

    assign branch_sext = {{(PC_W - OFF_W){branch_off[OFF_W-1]}}, branch_off};
    assign start_ok    = ({1'b0, start_addr} < ProgLen);
    assign next_ok     = ({1'b0, next_pc} < ProgLen);

    always_comb begin
        next_pc = pc_q + {{(PC_W - 1){1'b0}}, 1'b1};
        if (jump_en) begin
            next_pc = jump_addr;
        end else if (branch_en) begin
            next_pc = pc_q + branch_sext;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StHalted, StFault: begin
                if (start) begin
                    if (start_ok) begin
                        pc_d    = start_addr;
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        state_d = StFault;
                    end
                end
            end
            StRun: begin
                if (halt) begin
                    state_d = StHalted;
                end else if (!stall) begin
                    if (next_ok) begin
                        pc_d  = next_pc;
                        cnt_d = cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
                    end else begin
                        // pc keeps the last in-range address for post-mortem.
                        state_d = StFault;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc        = pc_q;
    assign fetch_cnt = cnt_q;
    assign pc_valid  = (state_q == StRun);
    assign done      = (state_q == StHalted) || (state_q == StFault);
    assign fault     = (state_q == StFault);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: sequencing, redirects, stall/halt, faults, restart, reset.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] start_addr;
    logic        stall;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic        branch_en;
    logic [7:0]  branch_off;
    logic        halt;
    logic [15:0] pc;
    logic        pc_valid;
    logic        done;
    logic        fault;
    logic [15:0] fetch_cnt;

    int n_cmp;
    int n_fail;

    // {pc, pc_valid, done, fault, fetch_cnt}
    logic [34:0] obs;
    assign obs = {pc, pc_valid, done, fault, fetch_cnt};

    pc_fetch_ctrl #(
        .PC_W    (16),
        .OFF_W   (8),
        .PROG_LEN(256),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_addr(start_addr),
        .stall     (stall),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .branch_en (branch_en),
        .branch_off(branch_off),
        .halt      (halt),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .done      (done),
        .fault     (fault),
        .fetch_cnt (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start      = 1'b0;
        start_addr = 16'h0;
        stall      = 1'b0;
        jump_en    = 1'b0;
        jump_addr  = 16'h0;
        branch_en  = 1'b0;
        branch_off = 8'h0;
        halt       = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic start_at(input logic [15:0] a);
        start      = 1'b1;
        start_addr = a;
        step();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++;
        if (obs !== {16'h0000, 3'b000, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h exp %h", obs, {16'h0000, 3'b000, 16'd0});
        end
        rst_n = 1'b1;
        // Inputs other than start are ignored while idle.
        jump_en   = 1'b1;
        jump_addr = 16'h0033;
        step();
        jump_en = 1'b0;
        n_cmp++;
        if (obs !== {16'h0000, 3'b000, 16'd0}) begin
            n_fail++;
            $display("FAIL idle_ignores_jump: got %h exp %h", obs, {16'h0000, 3'b000, 16'd0});
        end
    endtask

    task automatic test_sequential();
        start_at(16'h0000);
        n_cmp++;
        if (obs !== {16'h0000, 3'b100, 16'd0}) begin
            n_fail++;
            $display("FAIL seq_start: got %h exp %h", obs, {16'h0000, 3'b100, 16'd0});
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            n_cmp++;
            if (obs !== {16'(i), 3'b100, 16'(i)}) begin
                n_fail++;
                $display("FAIL seq_inc%0d: got %h exp %h", i, obs, {16'(i), 3'b100, 16'(i)});
            end
        end
    endtask

    task automatic test_redirect();
        jump_en   = 1'b1;
        jump_addr = 16'h0010;
        step();
        jump_en = 1'b0;
        n_cmp++;
        if (obs !== {16'h0010, 3'b100, 16'd6}) begin
            n_fail++;
            $display("FAIL jump_0010: got %h exp %h", obs, {16'h0010, 3'b100, 16'd6});
        end
        branch_en  = 1'b1;
        branch_off = 8'hFC;
        step();
        n_cmp++;
        if (obs !== {16'h000C, 3'b100, 16'd7}) begin
            n_fail++;
            $display("FAIL branch_neg: got %h exp %h", obs, {16'h000C, 3'b100, 16'd7});
        end
        branch_off = 8'h05;
        step();
        n_cmp++;
        if (obs !== {16'h0011, 3'b100, 16'd8}) begin
            n_fail++;
            $display("FAIL branch_pos: got %h exp %h", obs, {16'h0011, 3'b100, 16'd8});
        end
        jump_en   = 1'b1;
        jump_addr = 16'h0040;
        step();
        jump_en   = 1'b0;
        branch_en = 1'b0;
        n_cmp++;
        if (obs !== {16'h0040, 3'b100, 16'd9}) begin
            n_fail++;
            $display("FAIL jump_over_branch: got %h exp %h", obs, {16'h0040, 3'b100, 16'd9});
        end
    endtask

    task automatic test_stall_halt();
        jump_en   = 1'b1;
        jump_addr = 16'h0007;
        step();
        jump_en = 1'b0;
        stall   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs !== {16'h0007, 3'b100, 16'd10}) begin
                n_fail++;
                $display("FAIL stall%0d: got %h exp %h", i, obs, {16'h0007, 3'b100, 16'd10});
            end
        end
        halt = 1'b1;
        step();
        stall = 1'b0;
        halt  = 1'b0;
        n_cmp++;
        if (obs !== {16'h0007, 3'b010, 16'd10}) begin
            n_fail++;
            $display("FAIL stall_halt: got %h exp %h", obs, {16'h0007, 3'b010, 16'd10});
        end
        step();
        n_cmp++;
        if (obs !== {16'h0007, 3'b010, 16'd10}) begin
            n_fail++;
            $display("FAIL halted_hold: got %h exp %h", obs, {16'h0007, 3'b010, 16'd10});
        end
    endtask

    task automatic test_fault();
        start_at(16'h00FE);
        step();
        n_cmp++;
        if (obs !== {16'h00FF, 3'b100, 16'd1}) begin
            n_fail++;
            $display("FAIL last_addr: got %h exp %h", obs, {16'h00FF, 3'b100, 16'd1});
        end
        step();
        n_cmp++;
        if (obs !== {16'h00FF, 3'b011, 16'd1}) begin
            n_fail++;
            $display("FAIL inc_past_end: got %h exp %h", obs, {16'h00FF, 3'b011, 16'd1});
        end
        start_at(16'h0002);
        n_cmp++;
        if (obs !== {16'h0002, 3'b100, 16'd0}) begin
            n_fail++;
            $display("FAIL restart_2: got %h exp %h", obs, {16'h0002, 3'b100, 16'd0});
        end
        branch_en  = 1'b1;
        branch_off = 8'hF0;
        step();
        branch_en = 1'b0;
        n_cmp++;
        if (obs !== {16'h0002, 3'b011, 16'd0}) begin
            n_fail++;
            $display("FAIL branch_below_0: got %h exp %h", obs, {16'h0002, 3'b011, 16'd0});
        end
        do_reset();
        start_at(16'h0100);
        n_cmp++;
        if (obs !== {16'h0000, 3'b011, 16'd0}) begin
            n_fail++;
            $display("FAIL start_out_of_range: got %h exp %h", obs, {16'h0000, 3'b011, 16'd0});
        end
    endtask

    task automatic test_restart();
        do_reset();
        start_at(16'h0000);
        step();
        step();
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        n_cmp++;
        if (obs !== {16'h0003, 3'b010, 16'd3}) begin
            n_fail++;
            $display("FAIL halt_at_3: got %h exp %h", obs, {16'h0003, 3'b010, 16'd3});
        end
        start_at(16'h0020);
        n_cmp++;
        if (obs !== {16'h0020, 3'b100, 16'd0}) begin
            n_fail++;
            $display("FAIL restart_from_halt: got %h exp %h", obs, {16'h0020, 3'b100, 16'd0});
        end
        step();
        jump_en   = 1'b1;
        jump_addr = 16'h0200;
        step();
        jump_en = 1'b0;
        n_cmp++;
        if (obs !== {16'h0021, 3'b011, 16'd1}) begin
            n_fail++;
            $display("FAIL jump_out_of_range: got %h exp %h", obs, {16'h0021, 3'b011, 16'd1});
        end
        start_at(16'h0020);
        n_cmp++;
        if (obs !== {16'h0020, 3'b100, 16'd0}) begin
            n_fail++;
            $display("FAIL restart_from_fault: got %h exp %h", obs, {16'h0020, 3'b100, 16'd0});
        end
    endtask

    task automatic test_async_reset_and_start_in_run();
        step();
        step();
        n_cmp++;
        if (obs !== {16'h0022, 3'b100, 16'd2}) begin
            n_fail++;
            $display("FAIL pre_reset_run: got %h exp %h", obs, {16'h0022, 3'b100, 16'd2});
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== {16'h0000, 3'b000, 16'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got %h exp %h", obs, {16'h0000, 3'b000, 16'd0});
        end
        #2;
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (obs !== {16'h0000, 3'b000, 16'd0}) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h exp %h", obs, {16'h0000, 3'b000, 16'd0});
        end
        start_at(16'h0030);
        start      = 1'b1;
        start_addr = 16'h0080;
        step();
        start = 1'b0;
        n_cmp++;
        if (obs !== {16'h0031, 3'b100, 16'd1}) begin
            n_fail++;
            $display("FAIL start_in_run: got %h exp %h", obs, {16'h0031, 3'b100, 16'd1});
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_redirect();
        test_stall_halt();
        test_fault();
        test_restart();
        test_async_reset_and_start_in_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
